// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of pending stores between MEM stage and data memory
//
// Drains one entry per cycle into the memory write port, but only on cycles
// without a load. Loads that hit a buffered word get the youngest matching
// data forwarded combinationally.
//
// Optional feature macro: STORE_COALESCE_EN
//   When defined, a store to the youngest entry's word address overwrites
//   that entry in place instead of allocating a new one.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   st_valid/addr/data, st_ready   store handshake from the core
//   ld_req, ld_addr                core load (owns the memory address port)
//   ld_hit, ld_data                forwarding result
//   mem_write, mem_addr, mem_write_data   memory port
//   empty, full, count             occupancy status
module store_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       st_valid,
   input  logic [ADDR_W-1:0]          st_addr,
   input  logic [DATA_W-1:0]          st_data,
   output logic                       st_ready,
   input  logic                       ld_req,
   input  logic [ADDR_W-1:0]          ld_addr,
   output logic                       ld_hit,
   output logic [DATA_W-1:0]          ld_data,
   output logic                       mem_write,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_write_data,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int WW = ADDR_W - 2;
   logic [WW-1:0]     addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;
   logic              drain, alloc, coal, fwd_hit;
   logic [DATA_W-1:0] fwd_data;
   logic              unused_bits;
   assign unused_bits = ^{st_addr[1:0], ld_addr[1:0]};
   assign empty = count_q == '0;
   assign full  = count_q == CW'(DEPTH);
   assign count = count_q;
   assign drain = !empty && !ld_req;
`ifdef STORE_COALESCE_EN
   logic [PW-1:0] yng;
   assign yng = tail_q - 1'b1;
   // a lone entry that is leaving this cycle cannot absorb the store
   assign coal = !empty && addr_q[yng] == st_addr[ADDR_W-1:2] && !(yng == head_q && drain);
`else
   assign coal = 1'b0;
`endif
   assign st_ready = !full || coal;
   assign alloc    = st_valid && st_ready && !coal;
   assign mem_write      = drain;
   assign mem_addr       = drain ? {addr_q[head_q], 2'b00} : ld_addr;
   assign mem_write_data = data_q[head_q];
   // walk oldest to youngest so the last match (youngest) wins
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < count_q && addr_q[head_q + PW'(i)] == ld_addr[ADDR_W-1:2]) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[head_q + PW'(i)];
         end
      end
   end
   assign ld_hit  = ld_req && fwd_hit;
   assign ld_data = ld_hit ? fwd_data : '0;
   assign head_d  = head_q + PW'(drain);
   assign tail_d  = tail_q + PW'(alloc);
   assign count_d = count_q + CW'(alloc) - CW'(drain);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end
   always_ff @(posedge clk) begin
      if (alloc) begin
         addr_q[tail_q] <= st_addr[ADDR_W-1:2];
         data_q[tail_q] <= st_data;
      end
`ifdef STORE_COALESCE_EN
      else if (st_valid && coal) data_q[yng] <= st_data;
`endif
   end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed self-checking bench for store_buffer
module tb_store_buffer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        st_valid = 1'b0;
   logic [31:0] st_addr = '0;
   logic [31:0] st_data = '0;
   logic        st_ready;
   logic        ld_req = 1'b0;
   logic [31:0] ld_addr = '0;
   logic        ld_hit;
   logic [31:0] ld_data;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic        empty, full;
   logic [2:0]  count;
   int n_chk = 0;
   int n_pass = 0;

   store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
      .mem_write(mem_write), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .empty(empty), .full(full), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic st(input logic v, input logic [31:0] a, input logic [31:0] d);
      st_valid = v;
      st_addr  = a;
      st_data  = d;
   endtask

   task automatic chk_mem(input string tag, input logic [31:0] a, input logic [31:0] d);
      chk({tag, "_we"}, 32'(mem_write), 32'd1);
      chk({tag, "_addr"}, mem_addr, a);
      chk({tag, "_data"}, mem_write_data, d);
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "_empty"}, 32'(empty), 32'd1);
      chk({tag, "_full"}, 32'(full), 32'd0);
      chk({tag, "_count"}, 32'(count), 32'd0);
      chk({tag, "_ready"}, 32'(st_ready), 32'd1);
      chk({tag, "_we"}, 32'(mem_write), 32'd0);
      chk({tag, "_hit"}, 32'(ld_hit), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      chk_rst("rst");
      cyc();
      rst = 1'b0;
      // in-order drain with ld_req=0
      st(1'b1, 32'h10, 32'hA);
      #1;
      chk("t1_ready", 32'(st_ready), 32'd1);
      chk("t1_we0", 32'(mem_write), 32'd0);
      cyc();
      st(1'b1, 32'h14, 32'hB);
      #1;
      chk_mem("t1_w0", 32'h10, 32'hA);
      cyc();
      st(1'b1, 32'h18, 32'hC);
      #1;
      chk_mem("t1_w1", 32'h14, 32'hB);
      cyc();
      st(1'b0, 32'h0, 32'h0);
      #1;
      chk_mem("t1_w2", 32'h18, 32'hC);
      chk("t1_cnt", 32'(count), 32'd1);
      cyc();
      chk("t1_empty", 32'(empty), 32'd1);
      chk("t1_we_end", 32'(mem_write), 32'd0);
      // fill while loads hold the port
      ld_req = 1'b1;
      ld_addr = 32'h100;
      for (int i = 0; i < 4; i++) begin
         st(1'b1, 32'h30 + 32'(4 * i), 32'(i + 1));
         #1;
         chk("t2_fill_ready", 32'(st_ready), 32'd1);
         chk("t2_fill_we", 32'(mem_write), 32'd0);
         cyc();
      end
      st(1'b1, 32'h40, 32'h5);
      #1;
      chk("t2_cnt4", 32'(count), 32'd4);
      chk("t2_full", 32'(full), 32'd1);
      chk("t2_ready0", 32'(st_ready), 32'd0);
      chk("t2_we0", 32'(mem_write), 32'd0);
      chk("t2_ldaddr", mem_addr, 32'h100);
      cyc();
      chk("t2_cnt_hold", 32'(count), 32'd4);
      // drop the load: drain resumes, store still rejected this cycle
      ld_req = 1'b0;
      #1;
      chk("t2_ready_full_drain", 32'(st_ready), 32'd0);
      chk_mem("t2_d0", 32'h30, 32'h1);
      cyc();
      chk("t2_cnt3", 32'(count), 32'd3);
      chk("t2_ready1", 32'(st_ready), 32'd1);
      chk_mem("t2_d1", 32'h34, 32'h2);
      cyc();
      st(1'b0, 32'h0, 32'h0);
      #1;
      chk("t2_cnt_sim", 32'(count), 32'd3);
      chk_mem("t2_d2", 32'h38, 32'h3);
      cyc();
      chk_mem("t2_d3", 32'h3C, 32'h4);
      cyc();
      chk_mem("t2_d4", 32'h40, 32'h5);
      cyc();
      chk("t2_empty", 32'(empty), 32'd1);
      // forwarding
      ld_req = 1'b1;
      ld_addr = 32'h22;
      st(1'b1, 32'h20, 32'h11);
      #1;
      chk("t3_same_cycle_miss", 32'(ld_hit), 32'd0);
      cyc();
      st(1'b1, 32'h20, 32'h22);
      #1;
      chk("t3_hit1", 32'(ld_hit), 32'd1);
      chk("t3_data1", ld_data, 32'h11);
      cyc();
      st(1'b0, 32'h0, 32'h0);
      #1;
      chk("t3_hit2", 32'(ld_hit), 32'd1);
      chk("t3_youngest", ld_data, 32'h22);
`ifdef STORE_COALESCE_EN
      chk("t3_cnt", 32'(count), 32'd1);
`else
      chk("t3_cnt", 32'(count), 32'd2);
`endif
      ld_addr = 32'h24;
      #1;
      chk("t3_miss", 32'(ld_hit), 32'd0);
      chk("t3_miss_data", ld_data, 32'h0);
      chk("t3_mem_addr", mem_addr, 32'h24);
      ld_req = 1'b0;
      ld_addr = 32'h20;
      #1;
      chk("t3_noreq_hit", 32'(ld_hit), 32'd0);
`ifdef STORE_COALESCE_EN
      chk_mem("t3_d0", 32'h20, 32'h22);
      cyc();
`else
      chk_mem("t3_d0", 32'h20, 32'h11);
      cyc();
      chk_mem("t3_d1", 32'h20, 32'h22);
      cyc();
`endif
      chk("t3_empty", 32'(empty), 32'd1);
      // async reset mid-drain
      ld_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         st(1'b1, 32'h50 + 32'(4 * i), 32'(32'h60 + i));
         cyc();
      end
      st(1'b0, 32'h0, 32'h0);
      ld_req = 1'b0;
      #1;
      chk("t5_cnt3", 32'(count), 32'd3);
      chk_mem("t5_d0", 32'h50, 32'h60);
      rst = 1'b1;
      #1;
      chk_rst("t5_async");
      cyc();
      chk_rst("t5_held");
      rst = 1'b0;
      st(1'b1, 32'h60, 32'h77);
      #1;
      chk("t5_we_after", 32'(mem_write), 32'd0);
      chk("t5_ready", 32'(st_ready), 32'd1);
      cyc();
      st(1'b0, 32'h0, 32'h0);
      #1;
      chk("t5_cnt1", 32'(count), 32'd1);
      chk_mem("t5_d_new", 32'h60, 32'h77);
      cyc();
      chk("t5_empty", 32'(empty), 32'd1);
`ifdef STORE_COALESCE_EN
      ld_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         st(1'b1, 32'h70 + 32'(4 * i), 32'(i + 1));
         cyc();
      end
      st(1'b1, 32'h7C, 32'h99);
      #1;
      chk("t6_full", 32'(full), 32'd1);
      chk("t6_ready", 32'(st_ready), 32'd1);
      cyc();
      st(1'b0, 32'h0, 32'h0);
      ld_req = 1'b0;
      #1;
      chk("t6_cnt", 32'(count), 32'd4);
      chk_mem("t6_d0", 32'h70, 32'h1);
      cyc();
      cyc();
      cyc();
      chk_mem("t6_d3", 32'h7C, 32'h99);
      cyc();
      chk("t6_empty", 32'(empty), 32'd1);
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Small in-order FIFO of pending stores between the core's MEM stage and the word-addressed data memory.
- Accepts stores in one cycle and drains one entry per cycle into the memory's write port, but only on cycles when the core is not issuing a load.
- Loads to a buffered word are forwarded from the youngest matching entry, so the pipeline never reads stale memory.

Parameters:
DEPTH, 4, number of buffered stores (power of 2, >=2)
ADDR_W, 32, byte address width
DATA_W, 32, store data width (one word)

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset; asynchronous, active-high
st_valid  in  1  core presents a store this cycle
st_addr  in  ADDR_W  store byte address (bits [1:0] ignored)
st_data  in  DATA_W  store data
st_ready  out  1  buffer can accept the store this cycle
ld_req  in  1  core performs a load this cycle (owns the memory address port)
ld_addr  in  ADDR_W  load byte address
ld_hit  out  1  load word address matches a buffered entry
ld_data  out  DATA_W  forwarded data from the youngest matching entry
mem_write  out  1  memory write enable
mem_addr  out  ADDR_W  memory address: head entry when draining, else ld_addr
mem_write_data  out  DATA_W  head entry data
empty  out  1  no valid entries
full  out  1  count == DEPTH
count  out  $clog2(DEPTH)+1  number of valid entries

Behaviour:
Storage and reset
- Circular array with head/tail pointers and a count register.
- Reset (async, any cycle, including mid-drain) clears head, tail and count to 0 and discards all entries.
- Reset output values: empty=1, full=0, count=0, st_ready=1, mem_write=0, ld_hit=0.
- Entry contents are don't-care after reset.

Handshake and draining
- st_ready = !full; the cycle's drain is not considered.
- Enqueue when st_valid && st_ready: entry written at tail on posedge; tail wraps DEPTH-1 -> 0.
- drain = !empty && !ld_req (combinational).
- When drain=1: mem_write=1, mem_addr=head addr, mem_write_data=head data. The memory commits on the same posedge, and head advances/wraps.
- When drain=0: mem_write=0, mem_addr=ld_addr.
- Enqueue and drain in the same cycle: both occur, count unchanged.
- Enqueue while full is rejected (st_ready=0) even if a drain happens that cycle. The core must hold st_valid/addr/data until it sees st_ready.
- A store enqueued in cycle N is at the earliest drained in cycle N+1.
- Stores drain strictly in program order; duplicate addresses occupy separate entries.

Forwarding (combinational)
- Compare ld_addr[ADDR_W-1:2] against all valid entries' word addresses.
- ld_hit = ld_req && any match. ld_data = data of the youngest match (closest to tail).
- ld_data = 0 when ld_hit=0.
- A store being enqueued in the same cycle is not visible to forwarding.
- An entry being drained in the same cycle is still visible.

Optional Feature:
- Macro: STORE_COALESCE_EN.
- Defined: a store whose word address equals the youngest valid entry's word address overwrites that entry's data in place; no allocation, count unchanged.
  - Coalescing is blocked when that youngest entry is the head and drain=1 that cycle; the store then allocates normally.
  - st_ready = !full || coalesce_possible.
- Undefined: every accepted store allocates a new entry; st_ready = !full.

Test Plan:
- Reset, then 3 stores (0x10=0xA, 0x14=0xB, 0x18=0xC) with ld_req=0 -> memory writes appear in order on 3 consecutive cycles starting the cycle after the first enqueue; empty=1 afterwards.
- Hold ld_req=1 and issue 5 stores at DEPTH=4 -> count reaches 4, full=1, st_ready=0 on the 5th; mem_write stays 0. Drop ld_req -> drain resumes and the 5th store is accepted after the first drain.
- Buffer 0x20=0x11 then 0x20=0x22 with ld_req=1, load 0x22 -> ld_hit=1, ld_data=0x22 (youngest, byte offset ignored); load 0x24 -> ld_hit=0, mem_addr=0x24.
- Full buffer, ld_req=0, st_valid=1 -> store rejected that cycle, head drains, count 4->3; next cycle store accepted, count stays 3 (simultaneous enqueue/drain).
- Assert rst mid-drain with count=3 -> outputs take reset values immediately (asynchronously); no further mem_write; stores accepted normally after release.
- With STORE_COALESCE_EN and a full buffer, ld_req=1, store to the youngest entry's address -> accepted, count stays 4, later drained value is the new data.
